// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// Holds the FSM state encoding and the default operand width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/halfAdder.sv
// Single-bit half adder cell: s = a ^ b, c = a & b.
// Combinational, no backpressure.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built from half-adder pairs; {cout, sum} = a + b + cin.
// Purely combinational, no backpressure.
module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic s0, c0, c1;
    // Full adder: the two half-adder carries can never both be set, so OR merges them.
    halfAdder u_ha0 (.a(a[i]), .b(b[i]),     .s(s0),     .c(c0));
    halfAdder u_ha1 (.a(s0),   .b(carry[i]), .s(sum[i]), .c(c1));
    assign carry[i+1] = c0 | c1;
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per RUN cycle, WIDTH RUN cycles then a DONE cycle.
// Accepts start only in IDLE; starts in RUN/DONE are dropped, P holds until the next DONE.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               start,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  assign add_b = mult_q[0] ? mcand_q : '0;

  ripple_adder #(.WIDTH(WIDTH)) u_add (
    .a    (acc_q),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = A;
          mult_d  = B;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift {cout, sum, multiplier} right by one; the vacated carry bit becomes 0.
        acc_d   = {add_cout, add_sum[WIDTH-1:1]};
        mult_d  = {add_sum[0], mult_q[WIDTH-1:1]};
        carry_d = 1'b0;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          p_d     = {acc_d, mult_d};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign P    = p_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH 2, 4 and 8; table vectors plus abort/ignore/back-to-back sequences.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a2 = '0, b2 = '0;
  logic        s2 = 1'b0;
  logic [3:0]  p2;
  logic        busy2, done2;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        s4 = 1'b0;
  logic [7:0]  p4;
  logic        busy4, done4;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        s8 = 1'b0;
  logic [15:0] p8;
  logic        busy8, done8;

  seq_multiplier #(.WIDTH(2)) u2 (.clk(clk), .reset(rst), .A(a2), .B(b2), .start(s2), .P(p2), .busy(busy2), .done(done2));
  seq_multiplier #(.WIDTH(4)) u4 (.clk(clk), .reset(rst), .A(a4), .B(b4), .start(s4), .P(p4), .busy(busy4), .done(done4));
  seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .reset(rst), .A(a8), .B(b8), .start(s8), .P(p8), .busy(busy8), .done(done8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          w;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic [7:0] a, input logic [7:0] b, input logic s);
    case (w)
      2:       begin a2 = a[1:0]; b2 = b[1:0]; s2 = s; end
      4:       begin a4 = a[3:0]; b4 = b[3:0]; s4 = s; end
      default: begin a8 = a;      b8 = b;      s8 = s; end
    endcase
  endtask

  function automatic logic dn(input int w);
    return (w == 2) ? done2 : (w == 4) ? done4 : done8;
  endfunction

  function automatic logic bz(input int w);
    return (w == 2) ? busy2 : (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [15:0] pr(input int w);
    return (w == 2) ? {12'd0, p2} : (w == 4) ? {8'd0, p4} : p8;
  endfunction

  // One-cycle start pulse; operands are scrambled right after acceptance.
  // lat counts negedge samples after the one where start was driven.
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat, output bit busy_ok);
    @(negedge clk);
    set_in(w, a, b, 1'b1);
    lat = 0;
    busy_ok = 1'b1;
    p = '0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) set_in(w, ~a, ~b, 1'b0);
      if (!bz(w)) busy_ok = 1'b0;
      if (dn(w)) break;
    end
    p = pr(w);
    @(negedge clk);
    chk("idle_after_done", {31'd0, bz(w)}, 32'd0);
  endtask

  vec_t vt[$];

  initial begin
    logic [15:0] p;
    int lat, prev, ndone, nd;
    bit bok;
    string nm;

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        vt.push_back('{2, 8'(a), 8'(b), 16'(a * b)});
    vt.push_back('{4, 8'd15,  8'd15,  16'd225});
    vt.push_back('{4, 8'd6,   8'd7,   16'd42});
    vt.push_back('{4, 8'd0,   8'd9,   16'd0});
    vt.push_back('{4, 8'd8,   8'd1,   16'd8});
    vt.push_back('{4, 8'd13,  8'd11,  16'd143});
    vt.push_back('{8, 8'hFF,  8'h01,  16'h00FF});
    vt.push_back('{8, 8'h00,  8'hAB,  16'h0000});
    vt.push_back('{8, 8'hFF,  8'hFF,  16'hFE01});
    vt.push_back('{8, 8'h80,  8'h02,  16'h0100});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_p2", {28'd0, p2}, 0);
    chk("rst_p4", {24'd0, p4}, 0);
    chk("rst_p8", {16'd0, p8}, 0);
    chk("rst_busy", {29'd0, busy2, busy4, busy8}, 0);
    chk("rst_done", {29'd0, done2, done4, done8}, 0);

    foreach (vt[i]) begin
      do_op(vt[i].w, vt[i].a, vt[i].b, p, lat, bok);
      nm = $sformatf("w%0d_%0dx%0d", vt[i].w, vt[i].a, vt[i].b);
      chk({nm, "_p"}, {16'd0, p}, {16'd0, vt[i].p});
      chk({nm, "_lat"}, lat, vt[i].w + 1);
      chk({nm, "_busy"}, {31'd0, bok}, 1);
    end

    // Start re-pulsed during RUN must be ignored.
    @(negedge clk); set_in(4, 6, 7, 1'b1);
    @(negedge clk); set_in(4, 6, 7, 1'b0);
    @(negedge clk); set_in(4, 1, 1, 1'b1);
    @(negedge clk); set_in(4, 1, 1, 1'b0);
    lat = 3;
    while (!done4 && lat < 40) begin @(negedge clk); lat++; end
    chk("ignore_p", {24'd0, p4}, 42);
    chk("ignore_lat", lat, 5);
    repeat (3) @(negedge clk);
    chk("ignore_no_requeue", {31'd0, busy4}, 0);

    // Reset during the second RUN cycle aborts without a done pulse.
    @(negedge clk); set_in(4, 9, 9, 1'b1);
    @(negedge clk); set_in(4, 9, 9, 1'b0);
    @(negedge clk); rst = 1'b1; set_in(4, 2, 2, 1'b1);
    @(negedge clk); rst = 1'b0; set_in(4, 2, 2, 1'b0);
    chk("abort_busy", {31'd0, busy4}, 0);
    chk("abort_p", {24'd0, p4}, 0);
    chk("abort_done", {31'd0, done4}, 0);
    nd = 0;
    repeat (8) begin @(negedge clk); if (done4 || busy4) nd++; end
    chk("abort_quiet", nd, 0);
    do_op(4, 5, 3, p, lat, bok);
    chk("after_abort_p", {16'd0, p}, 15);
    chk("after_abort_lat", lat, 5);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk); set_in(4, 3, 4, 1'b1);
    prev = -1;
    ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done4) begin
        ndone++;
        chk("hold_p", {24'd0, p4}, 12);
        if (prev < 0) chk("hold_first", c, 5);
        else chk("hold_period", c - prev, 6);
        prev = c;
      end
    end
    set_in(4, 0, 0, 1'b0);
    chk("hold_count", ndone, 3);
    nd = 0;
    while (busy4 && nd < 20) begin @(negedge clk); nd++; end
    chk("hold_drain", {31'd0, busy4}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
